mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester read arbiter sharing a single SRAM read port between fetch and load units.
// Round-robin on ties, one outstanding transaction, outputs forced to zero while in reset.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ifu_araddr_i,
  input  logic        ifu_arvalid_i,
  output logic        ifu_arready_o,
  output logic [31:0] ifu_rdata_o,
  output logic [1:0]  ifu_rresp_o,
  output logic        ifu_rvalid_o,
  input  logic        ifu_rready_i,
  input  logic [31:0] lsu_araddr_i,
  input  logic        lsu_arvalid_i,
  output logic        lsu_arready_o,
  output logic [31:0] lsu_rdata_o,
  output logic [1:0]  lsu_rresp_o,
  output logic        lsu_rvalid_o,
  input  logic        lsu_rready_i,
  output logic [31:0] mem_araddr_o,
  output logic        mem_arvalid_o,
  input  logic        mem_arready_i,
  input  logic [31:0] mem_rdata_i,
  input  logic [1:0]  mem_rresp_i,
  input  logic        mem_rvalid_i,
  output logic        mem_rready_o
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  localparam logic OwnIfu = 1'b0;
  localparam logic OwnLsu = 1'b1;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (ifu_arvalid_i && lsu_arvalid_i) begin
          owner_d = ~last_q;
          state_d = StAddr;
        end else if (ifu_arvalid_i) begin
          owner_d = OwnIfu;
          state_d = StAddr;
        end else if (lsu_arvalid_i) begin
          owner_d = OwnLsu;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (mem_arvalid_o && mem_arready_i) state_d = StData;
      end
      StData: begin
        if (mem_rvalid_i && mem_rready_o) begin
          state_d = StIdle;
          last_d  = owner_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= OwnIfu;
      last_q  <= OwnIfu;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Gating with rst keeps every output at zero while a reset edge is pending.
  always_comb begin
    ifu_arready_o = 1'b0;
    ifu_rdata_o   = '0;
    ifu_rresp_o   = '0;
    ifu_rvalid_o  = 1'b0;
    lsu_arready_o = 1'b0;
    lsu_rdata_o   = '0;
    lsu_rresp_o   = '0;
    lsu_rvalid_o  = 1'b0;
    mem_araddr_o  = '0;
    mem_arvalid_o = 1'b0;
    mem_rready_o  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StAddr: begin
          if (owner_q == OwnLsu) begin
            mem_araddr_o  = lsu_araddr_i;
            mem_arvalid_o = lsu_arvalid_i;
            lsu_arready_o = mem_arready_i;
          end else begin
            mem_araddr_o  = ifu_araddr_i;
            mem_arvalid_o = ifu_arvalid_i;
            ifu_arready_o = mem_arready_i;
          end
        end
        StData: begin
          if (owner_q == OwnLsu) begin
            mem_rready_o = lsu_rready_i;
            lsu_rvalid_o = mem_rvalid_i;
            lsu_rdata_o  = mem_rdata_i;
            lsu_rresp_o  = mem_rresp_i;
          end else begin
            mem_rready_o = ifu_rready_i;
            ifu_rvalid_o = mem_rvalid_i;
            ifu_rdata_o  = mem_rdata_i;
            ifu_rresp_o  = mem_rresp_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios followed by a randomized run checked against a transaction-level model
// of two requesters and an SRAM with variable response delay.
module tb_mem_arbiter;

  localparam logic [31:0] K = 32'hA5A5_5A5A;

  logic        clk, rst;
  logic [31:0] ifu_araddr, lsu_araddr, mem_araddr, ifu_rdata, lsu_rdata, mem_rdata;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;
  logic [1:0]  ifu_rresp, lsu_rresp, mem_rresp;
  logic [105:0] outs;

  int n_assert, n_fail;
  int who, deliveries, completions, exp_next;
  logic [31:0] rd;
  logic        pend [2];
  logic        waitd [2];
  logic [31:0] addr [2];
  int          wait_cnt [2];
  logic        sram_busy;
  logic [31:0] sram_addr;
  int          sram_delay;
  logic        ah0, ah1, mah, dh0, dh1, mdh;

  mem_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_araddr_i  (ifu_araddr),
    .ifu_arvalid_i (ifu_arvalid),
    .ifu_arready_o (ifu_arready),
    .ifu_rdata_o   (ifu_rdata),
    .ifu_rresp_o   (ifu_rresp),
    .ifu_rvalid_o  (ifu_rvalid),
    .ifu_rready_i  (ifu_rready),
    .lsu_araddr_i  (lsu_araddr),
    .lsu_arvalid_i (lsu_arvalid),
    .lsu_arready_o (lsu_arready),
    .lsu_rdata_o   (lsu_rdata),
    .lsu_rresp_o   (lsu_rresp),
    .lsu_rvalid_o  (lsu_rvalid),
    .lsu_rready_i  (lsu_rready),
    .mem_araddr_o  (mem_araddr),
    .mem_arvalid_o (mem_arvalid),
    .mem_arready_i (mem_arready),
    .mem_rdata_i   (mem_rdata),
    .mem_rresp_i   (mem_rresp),
    .mem_rvalid_i  (mem_rvalid),
    .mem_rready_o  (mem_rready)
  );

  assign outs = {ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid,
                 lsu_arready, lsu_rdata, lsu_rresp, lsu_rvalid,
                 mem_araddr, mem_arvalid, mem_rready};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ifu_araddr = '0; ifu_arvalid = 1'b0; ifu_rready = 1'b1;
    lsu_araddr = '0; lsu_arvalid = 1'b0; lsu_rready = 1'b1;
    mem_arready = 1'b0; mem_rdata = '0; mem_rresp = '0; mem_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Wait for a grant, then return data; reports who got the data and its value.
  task automatic serve(input logic [31:0] data, output int w, output logic [31:0] r);
    w = -1;
    mem_arready = 1'b1;
    mem_rvalid  = 1'b0;
    for (int i = 0; i < 10 && w < 0; i++) begin
      #1;
      if (ifu_arready) w = 0;
      else if (lsu_arready) w = 1;
      tick();
    end
    mem_arready = 1'b0;
    mem_rvalid  = 1'b1;
    mem_rdata   = data;
    #1;
    w = ifu_rvalid ? 0 : (lsu_rvalid ? 1 : -1);
    r = ifu_rvalid ? ifu_rdata : lsu_rdata;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;

    // Reset: outputs zero during and after, even with requests present
    clr();
    rst = 1'b1;
    ifu_arvalid = 1'b1;
    lsu_arvalid = 1'b1;
    tick();
    #1 chk("reset_outs", 128'(outs), 128'(0));
    tick();
    rst = 1'b0;
    ifu_arvalid = 1'b0;
    lsu_arvalid = 1'b0;
    #1 chk("post_reset_outs", 128'(outs), 128'(0));
    tick();

    // Tie after reset: strict alternation starting with LSU
    ifu_arvalid = 1'b1;
    lsu_arvalid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      serve(32'h1000 + 32'(k), who, rd);
      chk("tie_order", 128'(who), 128'((k % 2 == 0) ? 1 : 0));
      chk("tie_data", 128'(rd), 128'(32'h1000 + 32'(k)));
    end

    // Fetch only
    do_reset();
    ifu_arvalid = 1'b1;
    ifu_araddr  = 32'h8000_0000;
    mem_arready = 1'b1;
    #1 chk("fetch_idle_arready", 128'(ifu_arready), 128'(0));
    tick();
    #1 chk("fetch_arready", 128'(ifu_arready), 128'(1));
    chk("fetch_mem_addr", 128'({mem_araddr, mem_arvalid}), 128'({32'h8000_0000, 1'b1}));
    tick();
    ifu_arvalid = 1'b0;
    mem_arready = 1'b0;
    mem_rvalid  = 1'b1;
    mem_rdata   = 32'h0000_0413;
    #1 chk("fetch_rdata", 128'({ifu_rvalid, ifu_rdata, ifu_rresp}), 128'({1'b1, 32'h413, 2'b00}));
    chk("fetch_lsu_quiet", 128'({lsu_arready, lsu_rdata, lsu_rresp, lsu_rvalid}), 128'(0));
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    #1 chk("fetch_done_idle", 128'(outs), 128'(0));

    // Backpressure on address then data
    do_reset();
    ifu_arvalid = 1'b1;
    ifu_araddr  = 32'h2000;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_addr_hold", 128'({ifu_arready, mem_arvalid}), 128'(2'b01));
      tick();
    end
    mem_arready = 1'b1;
    #1 chk("bp_addr_accept", 128'(ifu_arready), 128'(1));
    tick();
    ifu_arvalid = 1'b0;
    mem_arready = 1'b0;
    mem_rvalid  = 1'b1;
    mem_rdata   = 32'hBEEF;
    ifu_rready  = 1'b0;
    deliveries  = 0;
    for (int i = 0; i < 2; i++) begin
      #1 chk("bp_data_hold", 128'({ifu_rvalid, mem_rready}), 128'(2'b10));
      if (ifu_rvalid && ifu_rready) deliveries++;
      tick();
    end
    ifu_rready = 1'b1;
    #1 chk("bp_data", 128'({ifu_rdata, mem_rready}), 128'({32'hBEEF, 1'b1}));
    if (ifu_rvalid && ifu_rready) deliveries++;
    tick();
    #1 chk("bp_no_dup", 128'({ifu_rvalid, mem_rready}), 128'(0));
    if (ifu_rvalid && ifu_rready) deliveries++;
    chk("bp_deliveries", 128'(deliveries), 128'(1));
    tick();

    // Late LSU request during an IFU data phase
    do_reset();
    ifu_arvalid = 1'b1;
    ifu_araddr  = 32'h3000;
    lsu_araddr  = 32'h4000;
    mem_arready = 1'b1;
    tick();
    #1 chk("late_ifu_arready", 128'(ifu_arready), 128'(1));
    tick();
    ifu_arvalid = 1'b0;
    lsu_arvalid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1 chk("late_lsu_wait_data", 128'(lsu_arready), 128'(0));
      tick();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55;
    #1 chk("late_ifu_rdata", 128'({ifu_rdata, lsu_arready}), 128'({32'h55, 1'b0}));
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    #1 chk("late_lsu_wait_idle", 128'(lsu_arready), 128'(0));
    tick();
    #1 chk("late_lsu_grant", 128'({lsu_arready, mem_araddr}), 128'({1'b1, 32'h4000}));
    tick();
    lsu_arvalid = 1'b0;
    mem_rvalid  = 1'b1;
    mem_rdata   = 32'h66;
    #1 chk("late_lsu_rdata", 128'({lsu_rvalid, lsu_rdata}), 128'({1'b1, 32'h66}));
    tick();

    // Reset while waiting for data
    do_reset();
    ifu_arvalid = 1'b1;
    ifu_araddr  = 32'h5000;
    mem_arready = 1'b1;
    tick();
    tick();
    ifu_arvalid = 1'b0;
    #1 chk("rstd_in_data", 128'(mem_rready), 128'(1));
    rst = 1'b1;
    #1 chk("rstd_outs", 128'(outs), 128'(0));
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h77;
    #1 chk("rstd_late_rvalid", 128'(outs), 128'(0));
    tick();
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    lsu_arvalid = 1'b1;
    lsu_araddr  = 32'h6000;
    tick();
    #1 chk("rstd_new_grant", 128'({lsu_arready, mem_araddr}), 128'({1'b1, 32'h6000}));
    tick();
    lsu_arvalid = 1'b0;
    mem_rvalid  = 1'b1;
    mem_rdata   = 32'h88;
    #1 chk("rstd_new_rdata", 128'({lsu_rvalid, lsu_rdata}), 128'({1'b1, 32'h88}));
    tick();

    // Error response forwarded, no retry
    do_reset();
    lsu_arvalid = 1'b1;
    lsu_araddr  = 32'h7000;
    mem_arready = 1'b1;
    tick();
    tick();
    lsu_arvalid = 1'b0;
    mem_rvalid  = 1'b1;
    mem_rresp   = 2'b10;
    #1 chk("err_rresp", 128'({lsu_rvalid, lsu_rresp}), 128'({1'b1, 2'b10}));
    tick();
    mem_rvalid = 1'b0;
    mem_rresp  = 2'b00;
    #1 chk("err_idle", 128'(outs), 128'(0));
    tick();
    #1 chk("err_no_retry", 128'(outs), 128'(0));

    // Randomized traffic against a transaction-level model
    do_reset();
    for (int r = 0; r < 2; r++) begin
      pend[r] = 1'b0; waitd[r] = 1'b0; addr[r] = '0; wait_cnt[r] = 0;
    end
    sram_busy = 1'b0; sram_addr = '0; sram_delay = 0;
    completions = 0;
    exp_next = -1;
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && !waitd[r] && $urandom_range(0, 1) == 1) begin
          pend[r] = 1'b1;
          addr[r] = $urandom;
        end
      end
      ifu_arvalid = pend[0];
      ifu_araddr  = pend[0] ? addr[0] : $urandom;
      lsu_arvalid = pend[1];
      lsu_araddr  = pend[1] ? addr[1] : $urandom;
      ifu_rready  = 1'($urandom_range(0, 1));
      lsu_rready  = 1'($urandom_range(0, 1));
      mem_arready = 1'($urandom_range(0, 1));
      if (sram_busy && sram_delay == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = sram_addr ^ K;
        mem_rresp  = sram_addr[1:0];
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        mem_rresp  = '0;
      end
      #1;
      ah0 = ifu_arvalid & ifu_arready;
      ah1 = lsu_arvalid & lsu_arready;
      mah = mem_arvalid & mem_arready;
      dh0 = ifu_rvalid & ifu_rready;
      dh1 = lsu_rvalid & lsu_rready;
      mdh = mem_rvalid & mem_rready;
      chk("rnd_one_arready", 128'(ifu_arready & lsu_arready), 128'(0));
      chk("rnd_one_rvalid", 128'(ifu_rvalid & lsu_rvalid), 128'(0));
      chk("rnd_addr_hs", 128'(mah), 128'(ah0 | ah1));
      chk("rnd_data_hs", 128'(mdh), 128'(dh0 | dh1));
      chk("rnd_ifu_quiet", 128'(ifu_rvalid ? 34'h0 : {ifu_rdata, ifu_rresp}), 128'(0));
      chk("rnd_lsu_quiet", 128'(lsu_rvalid ? 34'h0 : {lsu_rdata, lsu_rresp}), 128'(0));
      if (mah) begin
        who = ah1 ? 1 : 0;
        chk("rnd_addr_value", 128'(mem_araddr), 128'(addr[who]));
        chk("rnd_single_outstanding", 128'({sram_busy, waitd[0], waitd[1]}), 128'(0));
        if (exp_next >= 0) chk("rnd_round_robin", 128'(who), 128'(exp_next));
        exp_next   = -1;
        pend[who]  = 1'b0;
        waitd[who] = 1'b1;
        sram_busy  = 1'b1;
        sram_addr  = addr[who];
        sram_delay = $urandom_range(0, 3);
      end else if (sram_busy && sram_delay > 0) begin
        sram_delay--;
      end
      if (mdh) begin
        who = dh1 ? 1 : 0;
        chk("rnd_data_owner", 128'(waitd[who]), 128'(1));
        chk("rnd_rdata", 128'(who == 1 ? lsu_rdata : ifu_rdata), 128'(sram_addr ^ K));
        chk("rnd_rresp", 128'(who == 1 ? lsu_rresp : ifu_rresp), 128'(sram_addr[1:0]));
        waitd[who] = 1'b0;
        sram_busy  = 1'b0;
        completions++;
        exp_next = pend[1 - who] ? 1 - who : -1;
      end
      for (int r = 0; r < 2; r++) begin
        wait_cnt[r] = pend[r] ? wait_cnt[r] + 1 : 0;
        chk("rnd_no_starve", 128'(wait_cnt[r] > 60), 128'(0));
      end
      tick();
    end
    chk("rnd_progress", 128'(completions > 100), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
